// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: processes a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR operation DIGIT bits
// per clock, LSB digit first, with a start/busy/done handshake and registered flags.
module digit_serial_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluCtl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_d;
  logic             carry_out_d, overflow_d, zero_d, busy_d, done_d;

  logic [DIGIT-1:0] da, db, dsum, dres;
  logic [DIGIT:0]   c;
  logic             c_msb, c_out, ovf, set_bit, last, addsub;
  logic [WIDTH-1:0] res_shift, final_res;

  // One digit of the bit-slice array; operand shadows shift right so the live digit is always at bit 0
  always_comb begin
    da   = a_q[DIGIT-1:0] ^ {DIGIT{ctl_q[3]}};
    db   = b_q[DIGIT-1:0] ^ {DIGIT{ctl_q[2]}};
    dsum = '0;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i]  = da[i] ^ db[i] ^ c[i];
      c[i+1]   = (da[i] & db[i]) | (da[i] & c[i]) | (db[i] & c[i]);
    end
    case (ctl_q[1:0])
      2'b00:   dres = da & db;
      2'b01:   dres = da | db;
      2'b10:   dres = dsum;
      default: dres = '0;
    endcase
    c_msb     = c[DIGIT-1];
    c_out     = c[DIGIT];
    ovf       = c_msb ^ c_out;
    set_bit   = dsum[DIGIT-1] ^ ovf;
    last      = (cnt_q == CW'(NDIG - 1));
    addsub    = (ctl_q[1:0] == 2'b10);
    res_shift = (res_sh_q >> DIGIT) | (WIDTH'(dres) << (WIDTH - DIGIT));
    final_res = (ctl_q[1:0] == 2'b11) ? WIDTH'(set_bit) : res_shift;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctl_d       = ctl_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_sh_d    = res_sh_q;
    result_d    = result;
    carry_out_d = carryOut;
    overflow_d  = overflow;
    zero_d      = zero;
    busy_d      = busy;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          ctl_d    = aluCtl;
          carry_d  = aluCtl[2];
          cnt_d    = '0;
          res_sh_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        carry_d  = c_out;
        cnt_d    = cnt_q + CW'(1);
        res_sh_d = res_shift;
        if (last) begin
          result_d    = final_res;
          carry_out_d = addsub & c_out;
          overflow_d  = addsub & ovf;
          zero_d      = (final_res == '0);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_sh_q <= '0;
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_sh_q <= res_sh_d;
      result   <= result_d;
      carryOut <= carry_out_d;
      overflow <= overflow_d;
      zero     <= zero_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed bench for digit_serial_alu: WIDTH=8 with DIGIT=1 and DIGIT=4 instances
// driven from shared operand inputs, selected one at a time.
module tb_digit_serial_alu;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n, start, sel;
  logic [3:0] aluCtl;
  logic [7:0] in1, in2;
  logic       start8, start4;

  logic [7:0] r8, r4;
  logic       co8, ov8, z8, b8, d8;
  logic       co4, ov4, z4, b4, d4;

  logic [7:0] o_res;
  logic       o_co, o_ov, o_z, o_busy, o_done;

  int nvec = 0;
  int nerr = 0;
  int nlat, lat, seen, rcyc;

  always #5 clk = ~clk;

  assign start8 = start & ~sel;
  assign start4 = start & sel;
  assign o_res  = sel ? r4  : r8;
  assign o_co   = sel ? co4 : co8;
  assign o_ov   = sel ? ov4 : ov8;
  assign o_z    = sel ? z4  : z8;
  assign o_busy = sel ? b4  : b8;
  assign o_done = sel ? d4  : d8;

  digit_serial_alu #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start8), .aluCtl(aluCtl), .in1(in1), .in2(in2),
    .result(r8), .carryOut(co8), .overflow(ov8), .zero(z8), .busy(b8), .done(d8)
  );

  digit_serial_alu #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .aluCtl(aluCtl), .in1(in1), .in2(in2),
    .result(r4), .carryOut(co4), .overflow(ov4), .zero(z4), .busy(b4), .done(d4)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s (sel=%0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s (sel=%0d): observed %b expected %b", tag, sel, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs == exp) else begin
      nerr++;
      $error("FAIL %s (sel=%0d): observed %0d expected %0d", tag, sel, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    aluCtl = ctl; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done; optionally keeps poking start and operands while busy
  task automatic wait_done(input bit wig, output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      chk1("busy_run", o_busy, 1'b1);
      if (wig) begin
        @(negedge clk);
        start = 1'b1; in1 = in1 + 8'h11; in2 = in2 ^ 8'h5A;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk1("busy_clr", o_busy, 1'b0);
  endtask

  task automatic check_out(input string tag, input int n, input logic [7:0] er,
                           input logic ec, input logic ev, input logic ez);
    chki({tag, "_latency"}, n, nlat);
    chk1({tag, "_done"}, o_done, 1'b1);
    chk8({tag, "_result"}, o_res, er);
    chk1({tag, "_carryOut"}, o_co, ec);
    chk1({tag, "_overflow"}, o_ov, ev);
    chk1({tag, "_zero"}, o_z, ez);
  endtask

  task automatic op(input string tag, input logic [3:0] ctl, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] er,
                    input logic ec, input logic ev, input logic ez);
    int n;
    launch(ctl, a, b);
    wait_done(1'b0, n);
    check_out(tag, n, er, ec, ev, ez);
    @(posedge clk); #1;
    chk1({tag, "_done_pulse"}, o_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0;
    aluCtl = 4'h0; in1 = 8'h00; in2 = 8'h00;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk8("rst_result", o_res, 8'h00);
      chk1("rst_carryOut", o_co, 1'b0);
      chk1("rst_overflow", o_ov, 1'b0);
      chk1("rst_zero", o_z, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_done", o_done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel  = s[0];
      nlat = (s == 0) ? 8 : 2;
      rcyc = (s == 0) ? 3 : 1;

      op("add_ovf",  C_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
      op("sub_eq",   C_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
      op("sub_ovf",  C_SUB, 8'h7F, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b0);
      op("slt_neg",  C_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
      op("slt_ovf",  C_SLT, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
      op("slt_eq",   C_SLT, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1);
      op("and",      C_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
      op("or",       C_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
      op("nor",      C_NOR, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0);

      // start and operand churn while busy must not disturb the captured operation
      launch(C_ADD, 8'h12, 8'h34);
      wait_done(1'b1, lat);
      check_out("busy_ignore", lat, 8'h46, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk1("busy_ignore_no_requeue", o_busy, 1'b0);

      // back-to-back: second start presented during the done cycle
      launch(C_SUB, 8'h05, 8'h05);
      wait_done(1'b0, lat);
      check_out("b2b_first", lat, 8'h00, 1'b1, 1'b0, 1'b1);
      aluCtl = C_ADD; in1 = 8'h7F; in2 = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk1("b2b_done_pulse", o_done, 1'b0);
      chk8("b2b_hold_result", o_res, 8'h00);
      wait_done(1'b0, lat);
      check_out("b2b_second", lat, 8'h80, 1'b0, 1'b1, 1'b0);

      // asynchronous reset in the middle of an operation
      launch(C_ADD, 8'h12, 8'h34);
      repeat (rcyc - 1) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk8("midrst_result", o_res, 8'h00);
      chk1("midrst_carryOut", o_co, 1'b0);
      chk1("midrst_overflow", o_ov, 1'b0);
      chk1("midrst_busy", o_busy, 1'b0);
      chk1("midrst_done", o_done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (o_done === 1'b1) seen++;
      end
      chki("midrst_no_done", seen, 0);
      chk8("midrst_result_held", o_res, 8'h00);
      op("add_after_rst", C_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/digit_serial_alu.md
Name: digit_serial_alu

Overview:
- Parametrised multi-cycle successor to the 1-bit ALU slice.
- Processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first, using a registered carry between digits.
- Supports AND, OR, ADD, SUB, SLT and NOR, with start/busy/done handshake and registered result flags.
- Sits between the register file and the datapath control FSM in the multi-cycle core.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0. DIGIT=WIDTH is legal and gives single-cycle processing.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- aluCtl  input  4  {ainvert, bnegate, op[1:0]}; op codes: 0=AND, 1=OR, 2=ADD, 3=SLT
- in1  input  WIDTH  operand A (two's complement)
- in2  input  WIDTH  operand B (two's complement)
- result  output  WIDTH  final result, registered
- carryOut  output  1  carry out of MSB for ADD/SUB; 0 otherwise
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise
- zero  output  1  result == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when result/flags update

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, carryOut=0, overflow=0, zero=0, busy=0, done=0; internal carry and digit counter cleared. Applies immediately, including mid-operation. The aborted operation never produces done.
- Legal aluCtl encodings: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. Other encodings decode per the bit fields; outputs for them are don't-care but must be deterministic.
- Per-bit slice: a' = in1 ^ ainvert, b' = in2 ^ bnegate.
  - op0 gives a'&b'; op1 gives a'|b'; op2 gives the sum bit.
  - op3 gives 0, except result bit0, which is set = MSB sum bit XOR overflow.
  - Carry-in of bit 0 = bnegate.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge k captures in1, in2 and aluCtl into shadow registers.
  - Sets busy=1, loads the carry register with bnegate, digit count=0, goes to RUN.
  - Input changes after edge k have no effect.
- RUN:
  - Each edge processes digit[count] and stores DIGIT result bits into the result shadow.
  - Carry out of the digit's top bit is stored for the next digit; count increments.
  - On the last digit (count = WIDTH/DIGIT - 1), the same edge:
    - computes carry into MSB (cMSB) and carry out of MSB (cOut);
    - overflow = cMSB ^ cOut; set = sumMSB ^ overflow;
    - for SLT, writes result = {0..0, set};
    - updates result, carryOut, overflow (ADD/SUB only, else 0) and zero;
    - pulses done=1, clears busy, returns to IDLE.
- Latency: done is high during the cycle after edge k + WIDTH/DIGIT, i.e. N = WIDTH/DIGIT cycles after start is accepted.
- Outputs hold their last values until the next completion; result is never partially visible.
- start while busy=1 is ignored and not queued.
- start=1 during the done cycle (busy=0) is accepted, giving back-to-back operations with no bubble.
- SLT uses the true subtraction sign, so it is correct when a-b overflows.

Test Plan:
- WIDTH=8, DIGIT=1, ADD (0010) 0x7F + 0x01 -> result=0x80, overflow=1, carryOut=0, zero=0; done exactly 8 cycles after start edge, single-cycle pulse; busy high for cycles 1..8.
- SUB (0110): 0x05 - 0x05 -> 0x00, zero=1, carryOut=1, overflow=0. Then 0x7F - 0x80 -> 0xFF, overflow=1, carryOut=0.
- SLT (0111): 0x80 vs 0x01 -> 0x01. 0x7F vs 0x80 -> 0x00 (overflow case). 0x03 vs 0x03 -> 0x00, zero=1. carryOut=0 and overflow=0 in all three.
- Logic ops with in1=0xF0, in2=0x3C: AND -> 0x30; OR -> 0xFC; NOR (1100) -> 0x03; carryOut=overflow=0.
- Handshake:
  - pulse start with operands changed every cycle during busy -> second start ignored, result uses captured operands;
  - start asserted in the done cycle -> second done exactly 8 cycles later.
- Reset and digit width:
  - rst_n low 3 cycles into an ADD -> all outputs 0 immediately, no done;
  - after release, ADD 0x12 + 0x34 -> 0x46.
  - Repeat with DIGIT=4 -> done 2 cycles after start, same results.
